// File: rtl/risc_pkg.sv
// Shared definitions for the fetch/decode slice: fetch FSM states and PC defaults
// used by both the fetch unit and the PC-select logic.
package risc_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_DONE
   } fetch_state_t;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
   localparam logic [63:0] DEFAULT_PC_STEP  = 64'd4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: request/address from the fetch unit,
// ready/data back from the memory.
interface instr_fetch_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic               mem_rd;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ready;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC, issues instruction-memory reads and hands each
// fetched word to the instruction register with a one-cycle load_ir strobe.
module instr_fetch
   import risc_pkg::*;
#(
   parameter int               ADDR_W   = 64,
   parameter int               INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   input  logic               pc_write,
   input  logic [ADDR_W-1:0]  pc_in,
   instr_fetch_if.master      mem,
   output logic [INSTR_W-1:0] instruction,
   output logic               load_ir,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               busy
);

   fetch_state_t       state_reg;
   logic [ADDR_W-1:0]  pc_reg;
   logic [ADDR_W-1:0]  target_reg;
   logic               pending_reg;
   logic               mem_rd_reg;
   logic               load_ir_reg;
   logic               busy_reg;
   logic [INSTR_W-1:0] instruction_reg;
   logic [ADDR_W-1:0]  pc_out_reg;
   logic [ADDR_W-1:0]  pc_in_aligned;

   // Redirect targets are word-aligned on entry; low bits are simply dropped.
   assign pc_in_aligned = {pc_in[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= FETCH_IDLE;
         pc_reg          <= RESET_PC;
         target_reg      <= '0;
         pending_reg     <= 1'b0;
         mem_rd_reg      <= 1'b0;
         load_ir_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         instruction_reg <= '0;
         pc_out_reg      <= '0;
      end else begin
         load_ir_reg <= 1'b0;
         case (state_reg)
            FETCH_IDLE: begin
               if (pc_write) begin
                  pc_reg <= pc_in_aligned;
               end else if (fetch_en) begin
                  state_reg  <= FETCH_REQ;
                  mem_rd_reg <= 1'b1;
                  busy_reg   <= 1'b1;
               end
            end
            FETCH_REQ: begin
               if (mem.mem_ready) begin
                  // A redirect seen at any point in this request voids the returned word;
                  // the request stays up and simply moves to the new PC.
                  if (pc_write) begin
                     pc_reg      <= pc_in_aligned;
                     pending_reg <= 1'b0;
                  end else if (pending_reg) begin
                     pc_reg      <= target_reg;
                     pending_reg <= 1'b0;
                  end else begin
                     instruction_reg <= mem.mem_rdata;
                     pc_out_reg      <= pc_reg;
                     pc_reg          <= pc_reg + PC_STEP;
                     load_ir_reg     <= 1'b1;
                     mem_rd_reg      <= 1'b0;
                     state_reg       <= FETCH_DONE;
                  end
               end else if (pc_write) begin
                  // Address must stay stable until the memory answers, so just remember the target.
                  target_reg  <= pc_in_aligned;
                  pending_reg <= 1'b1;
               end
            end
            FETCH_DONE: begin
               if (pc_write) begin
                  pc_reg <= pc_in_aligned;
               end
               state_reg <= FETCH_IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg  <= FETCH_IDLE;
               mem_rd_reg <= 1'b0;
               busy_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_rd   = mem_rd_reg;
   assign mem.mem_addr = pc_reg;
   assign instruction  = instruction_reg;
   assign load_ir      = load_ir_reg;
   assign pc_out       = pc_out_reg;
   assign busy         = busy_reg;

endmodule
